// File: rtl/onewire_slave_pkg.sv
// Shared types, timing defaults and the timer width helper for the 1-wire responder.
package onewire_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SLOT,
        RLOW,
        PWAIT,
        PDRV
    } state_t;

    localparam int CDR_DEF   = 24;
    localparam int T_SMP_DEF = 30;
    localparam int T_RST_DEF = 480;
    localparam int T_PDH_DEF = 30;
    localparam int T_PDL_DEF = 120;

    // The timer spans the longest reset low time plus the presence window.
    function automatic int timer_width(input int cdr, input int t_rst, input int t_pdl);
        return $clog2(cdr * (t_rst + t_pdl) + 1);
    endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the raw line level, followed by registered fall/rise pulses.
module onewire_sync (
    input  logic clk,
    input  logic rst,
    input  logic owr_i,
    output logic fall,
    output logic rise
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       fall_reg;
    logic       rise_reg;

    // Resync the line, keep the previous level and form one-cycle edge pulses.
    // An idle bus is high, so reset everything to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
            prev_reg <= 1'b1;
            fall_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], owr_i};
            prev_reg <= sync_reg[1];
            fall_reg <= prev_reg & ~sync_reg[1];
            rise_reg <= ~prev_reg & sync_reg[1];
        end
    end

    assign fall = fall_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/onewire_slave.sv
// 1-wire slave emulator: reset/presence handling, write-slot decoding into bytes
// and read-slot answering from a loaded byte.
module onewire_slave
    import onewire_slave_pkg::*;
#(
    parameter int CDR   = CDR_DEF,
    parameter int T_SMP = T_SMP_DEF,
    parameter int T_RST = T_RST_DEF,
    parameter int T_PDH = T_PDH_DEF,
    parameter int T_PDL = T_PDL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       owr_i,
    output logic       owr_e,
    output logic       rx_vld,
    output logic [7:0] rx_dat,
    input  logic       tx_vld,
    input  logic [7:0] tx_dat,
    output logic       tx_rdy,
    output logic       tx_done,
    output logic       bus_rst
);

    localparam int TW = timer_width(CDR, T_RST, T_PDL);
    localparam logic [TW-1:0] SMP_CYC     = TW'(CDR * T_SMP);
    localparam logic [TW-1:0] RST_CYC     = TW'(CDR * T_RST);
    localparam logic [TW-1:0] PDH_LAST    = TW'(CDR * T_PDH - 1);
    localparam logic [TW-1:0] PDRV_LAST   = TW'(CDR * (T_PDH + T_PDL) - 1);

    logic          fall;
    logic          rise;
    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg;
    logic [3:0]    bit_cnt_reg;
    logic          tx_mode_reg;
    logic [7:0]    tx_sh_reg;
    logic [7:0]    rx_sh_reg;
    logic [7:0]    rx_dat_reg;
    logic          rx_vld_reg;
    logic          tx_done_reg;
    logic          run_reg;
    logic          timer_clr;
    logic          bit_ev;
    logic          bit_val;
    logic          byte_abort;

    onewire_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .owr_i (owr_i),
        .fall  (fall),
        .rise  (rise)
    );

    // Free-running slot timer: restarted by the FSM, saturating at the reset threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (timer_clr) begin
            timer_reg <= '0;
        end else if (timer_reg < RST_CYC) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode, slot bit events and line drive.
    always_comb begin
        state_next = state_reg;
        timer_clr  = 1'b0;
        bit_ev     = 1'b0;
        bit_val    = 1'b0;
        byte_abort = 1'b0;
        owr_e      = 1'b0;
        bus_rst    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next = SLOT;
                    timer_clr  = 1'b1;
                    owr_e      = tx_mode_reg & ~tx_sh_reg[0];
                end
            end
            SLOT: begin
                // Hold the line low for a 0 read bit until the master's sample point.
                owr_e = tx_mode_reg & ~tx_sh_reg[0] & (timer_reg < SMP_CYC);
                if (rise) begin
                    state_next = IDLE;
                    if (timer_reg < SMP_CYC) begin
                        bit_ev  = 1'b1;
                        bit_val = 1'b1;
                    end
                end else if (timer_reg == SMP_CYC) begin
                    bit_ev  = 1'b1;
                    bit_val = 1'b0;
                end else if (timer_reg == RST_CYC) begin
                    state_next = RLOW;
                    byte_abort = 1'b1;
                end
            end
            RLOW: begin
                if (rise) begin
                    state_next = PWAIT;
                    bus_rst    = 1'b1;
                    timer_clr  = 1'b1;
                end
            end
            PWAIT: begin
                // Edges here are ignored; the timer runs on from the reset release.
                if (timer_reg == PDH_LAST) begin
                    state_next = PDRV;
                end
            end
            PDRV: begin
                owr_e = 1'b1;
                if (timer_reg == PDRV_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit counting, shift registers, tx loading and byte-complete strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg <= '0;
            tx_mode_reg <= 1'b0;
            tx_sh_reg   <= '0;
            rx_sh_reg   <= '0;
            rx_dat_reg  <= '0;
            rx_vld_reg  <= 1'b0;
            tx_done_reg <= 1'b0;
            run_reg     <= 1'b0;
        end else begin
            run_reg     <= 1'b1;
            rx_vld_reg  <= 1'b0;
            tx_done_reg <= 1'b0;
            if (tx_vld && tx_rdy) begin
                tx_sh_reg   <= tx_dat;
                tx_mode_reg <= 1'b1;
            end
            if (byte_abort) begin
                bit_cnt_reg <= '0;
                tx_mode_reg <= 1'b0;
            end else if (bit_ev) begin
                if (tx_mode_reg) begin
                    tx_sh_reg <= tx_sh_reg >> 1;
                end else begin
                    rx_sh_reg <= {bit_val, rx_sh_reg[7:1]};
                end
                if (bit_cnt_reg == 4'd7) begin
                    bit_cnt_reg <= '0;
                    if (tx_mode_reg) begin
                        tx_done_reg <= 1'b1;
                        tx_mode_reg <= 1'b0;
                    end else begin
                        rx_vld_reg <= 1'b1;
                        rx_dat_reg <= {bit_val, rx_sh_reg[7:1]};
                    end
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign rx_vld  = rx_vld_reg;
    assign rx_dat  = rx_dat_reg;
    assign tx_done = tx_done_reg;
    assign tx_rdy  = run_reg & (state_reg == IDLE) & (bit_cnt_reg == 4'd0) & ~tx_mode_reg;

endmodule
